// File: rtl/mp_tcm_arbiter.sv
// mp_tcm_arbiter: round-robin arbiter sharing one TCM port among N cores, broadcasting write invalidates
module mp_tcm_arbiter #(
  parameter int N = 4,
  parameter int AW = 16,
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    core_rd_req,
  input  logic [N-1:0]    core_wr_req,
  input  logic [N*AW-1:0] core_addr,
  input  logic [N*DW-1:0] core_wdata,
  output logic [N-1:0]    core_finish,
  output logic [DW-1:0]   core_rdata,
  output logic [N-1:0]    core_invalid,
  output logic [AW-1:0]   core_invalid_addr,
  output logic            tcm_rd,
  output logic            tcm_wr,
  output logic [AW-1:0]   tcm_addr,
  output logic [DW-1:0]   tcm_wdata,
  input  logic            tcm_done,
  input  logic [DW-1:0]   tcm_rdata,
  output logic            busy
);
  localparam int GW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [GW-1:0] ptr, g, nxt_g, idx;
  logic is_wr;
  logic [DW-1:0] rdata;
  logic [N-1:0] req, g_oh;
  assign req = core_rd_req | core_wr_req;
  assign g_oh = N'(1) << g;
  always_comb begin
    nxt_g = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % N);
      if (req[idx]) nxt_g = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      is_wr <= 1'b0;
      tcm_addr <= '0;
      tcm_wdata <= '0;
      rdata <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= XFER;
        g <= nxt_g;
        is_wr <= core_wr_req[nxt_g];
        tcm_addr <= core_addr[nxt_g*AW +: AW];
        tcm_wdata <= core_wdata[nxt_g*DW +: DW];
      end
    end else if (state == XFER) begin
      if (tcm_done) begin
        state <= RESP;
        if (!is_wr) rdata <= tcm_rdata;
      end
    end else begin
      state <= IDLE;
      ptr <= GW'((int'(g) + 1) % N);
    end
  assign tcm_rd = state == XFER && !is_wr;
  assign tcm_wr = state == XFER && is_wr;
  assign busy = state != IDLE;
  assign core_finish = state == RESP ? g_oh : '0;
  assign core_invalid = state == RESP && is_wr ? ~g_oh : '0;
  assign core_invalid_addr = tcm_addr;
  assign core_rdata = rdata;
endmodule

// File: doc/mp_tcm_arbiter.md
# mp_tcm_arbiter

Shares one tightly-coupled memory (TCM) port between N `mp` cores. Each core's `tcm_read_request` / `tcm_write_request` / `tcm_request_finish` line-transfer interface is served in round-robin order. Every completed write is broadcast to the other cores as a one-cycle `tcm_invalid` pulse so they drop stale dcache lines. The block sits between the core cluster and the single-ported TCM controller and runs one transaction at a time.

## Interface
- `N`, default 4: number of cores; 2..8.
- `AW`, default 16: line address width.
- `DW`, default 128: line data width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_rd_req` in N: per-core read request, held by the core until its finish pulse.
- `core_wr_req` in N: per-core write request, held by the core until its finish pulse.
- `core_addr` in N*AW: per-core address; core i uses bits [i*AW +: AW].
- `core_wdata` in N*DW: per-core write data; core i uses bits [i*DW +: DW].
- `core_finish` out N: one-cycle completion pulse to the granted core.
- `core_rdata` out DW: read data, shared by all cores; valid while `core_finish` is high.
- `core_invalid` out N: one-cycle invalidate pulse to every core except the writer.
- `core_invalid_addr` out AW: address of the invalidated line; valid while any `core_invalid` bit is high.
- `tcm_rd` out 1: read command to the TCM, held until `tcm_done`.
- `tcm_wr` out 1: write command to the TCM, held until `tcm_done`.
- `tcm_addr` out AW: registered command address.
- `tcm_wdata` out DW: registered write data.
- `tcm_done` in 1: one-cycle completion from the TCM.
- `tcm_rdata` in DW: TCM read data; valid with `tcm_done`.
- `busy` out 1: high in every state other than IDLE.

## Operation
- **State machine:** IDLE -> XFER -> RESP -> IDLE.
- **IDLE:**
  - `req[i] = core_rd_req[i] | core_wr_req[i]`.
  - If any `req` bit is set, grant the first requesting index at or after `ptr`, searching upward modulo N.
  - Register the grant index `g`, the address, the write data, and `is_wr = core_wr_req[g]`. If rd and wr are both set, the request is a write.
  - Go to XFER.
- **XFER:**
  - Drive `tcm_rd = !is_wr` and `tcm_wr = is_wr` from registers. Address and data are stable for the whole state.
  - On `tcm_done`: capture `tcm_rdata` into the `rdata` register (reads only), drop the command, go to RESP.
- **RESP:**
  - `core_finish[g] = 1` and `core_rdata = rdata register`.
  - If `is_wr`: `core_invalid = ~(1<<g)` and `core_invalid_addr = captured address`.
  - `ptr <= (g+1) mod N`. Go to IDLE.
- **Request dropped before finish:** the transaction still completes and the finish pulse is still issued. The core ignores it.
- **Re-grant guard:** the IDLE state after RESP sees the core's request already deasserted, because the core drops it on the finish edge. The same core is therefore never re-granted spuriously.
- **Address masking:** `core_addr` bits [3:0] are passed through unmodified. Line alignment is the TCM's concern.

## Timing
- **Reset values:**
  - state = IDLE, `ptr` = 0.
  - `tcm_rd`, `tcm_wr`, `core_finish`, `core_invalid`, `busy` all 0.
  - `tcm_addr`, `tcm_wdata`, `core_rdata`, `core_invalid_addr` all 0.
- **Uncontended latency:**
  - Request seen in IDLE at cycle 0.
  - `tcm_rd`/`tcm_wr` high from cycle 1.
  - `tcm_done` at cycle k (k >= 1).
  - `core_finish` at cycle k+1.
  - Earliest next grant decision at cycle k+2.
- **Throughput:** at most one transaction per (TCM latency + 2) cycles.
- **Fairness:** round-robin. With all N requesting continuously, each core waits at most N-1 transactions.
- **`tcm_done` outside XFER:** ignored, no state change.
- **Reset mid-transaction:** the TCM command drops asynchronously. No finish and no invalidate pulse is issued. The requester must re-issue.
- **Pulse exclusivity:** `core_finish` and `core_invalid` never target the same core in the same cycle.
- **Output stability:** all outputs come from registers or the state decode. There is no combinational path from `core_*` inputs to `tcm_*` outputs.

## Test plan
- **Reset:** hold `rst_n` = 0 while driving random requests. All outputs must stay 0. Release reset; the first grant goes to the lowest requesting index.
- **Single read:** core 2 reads address 0x0120; TCM answers `tcm_done` 3 cycles after `tcm_rd` with rdata 0xDEAD...BEEF.
  - `tcm_addr` = 0x0120 from cycle 1.
  - `core_finish` = 4'b0100 at cycle 5, with `core_rdata` = 0xDEAD...BEEF.
  - No `core_invalid` pulse.
- **Write broadcast:** core 1 writes 0x0040.
  - In RESP, `core_invalid` = 4'b1101 and `core_invalid_addr` = 0x0040.
  - `core_finish` = 4'b0010 in the same cycle.
- **Round-robin:** cores 0 to 3 request at once with `ptr` = 0 and hold their requests until finished.
  - Grant order is 0, 1, 2, 3.
  - Core 0 then re-requests while core 3 is in service. Core 0 is served next, and `ptr` ends at 1.
- **Reset mid-XFER:** assert `rst_n` = 0 while `tcm_wr` is high.
  - `tcm_wr` drops immediately and no finish or invalidate pulse is issued.
  - After release, the still-held request is re-granted and completes normally.
- **rd+wr conflict and stray done:**
  - Core 3 raises both `core_rd_req` and `core_wr_req`: the arbiter issues `tcm_wr`.
  - A `tcm_done` pulse injected in IDLE causes no `core_finish` pulse.
